// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the word/byte geometry of the instruction stream.
package cpu_pkg;

    localparam int WORD_BITS      = 32;
    localparam int BYTE_BITS      = 8;
    localparam int BYTES_PER_WORD = WORD_BITS / BYTE_BITS;

    // Loader states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } load_state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Little-endian byte-to-word assembler. Bytes shift in from the top so that
// after four bytes the first one received sits in bits [7:0].
module word_assembler
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic [BYTE_BITS-1:0] byte_in,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_full
);

    logic [WORD_BITS-1:0] shift_reg;
    logic [1:0]           lane_cnt;

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // The word including the byte being accepted right now, so the top can
    // register a complete word on the same edge as the fourth byte.
    assign word      = {byte_in, shift_reg[WORD_BITS-1:BYTE_BITS]};
    assign word_full = shift && (lane_cnt == LAST_LANE);

    // Shift register and byte-lane counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            lane_cnt  <= 2'd0;
        end else if (clear) begin
            shift_reg <= '0;
            lane_cnt  <= 2'd0;
        end else if (shift) begin
            shift_reg <= word;
            lane_cnt  <= lane_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader feeding the instruction memory of the
// single-cycle core. Parses a framed stream (length, payload, XOR checksum),
// writes words at sequential addresses and keeps the CPU held until a frame
// has been loaded and verified.
module instr_mem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH+1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    localparam logic [31:0]         MAX_WORDS = 32'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    load_state_t          state;
    load_state_t          state_next;
    logic                 xfer;
    logic                 restart;
    logic                 asm_shift;
    logic                 word_full;
    logic [WORD_BITS-1:0] asm_word;
    logic [7:0]           len_lo;
    logic [15:0]          n_len;
    logic [15:0]          len_full;
    logic [7:0]           xor_acc;
    logic [31:0]          cnt_after;
    logic                 last_word;

    // A byte may only be offered to the loader while it is parsing a frame;
    // this depends on state alone so the source never sees a ready that
    // reacts to its own valid.
    assign in_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CHECK);
    assign xfer      = in_valid && in_ready;
    assign asm_shift = xfer && (state == ST_DATA);
    assign len_full  = {in_data, len_lo};
    assign cnt_after = 32'(word_cnt) + 32'd1;
    assign last_word = (cnt_after == {16'd0, n_len});

    // Status is a pure function of state; a restart leaves DONE/ERROR and
    // therefore clears the sticky flags on the same edge.
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERROR);
    assign cpu_hold = (state != ST_IDLE) && (state != ST_DONE);

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart),
        .shift     (asm_shift),
        .byte_in   (in_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is honoured only outside an active frame
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    if ({16'd0, len_full} > MAX_WORDS) begin
                        state_next = ST_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_next = ST_CHECK;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_full && last_word) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_next = (in_data == xor_acc) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = ST_LEN_LO;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame datapath: length capture, running checksum and memory write port.
    // The write is registered, so mem_we pulses the cycle after the fourth
    // byte edge while the stream keeps flowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            word_cnt  <= '0;
            len_lo    <= 8'd0;
            n_len     <= 16'd0;
            xor_acc   <= 8'd0;
        end else begin
            mem_we <= word_full;
            if (restart) begin
                word_cnt <= '0;
                len_lo   <= 8'd0;
                n_len    <= 16'd0;
                xor_acc  <= 8'd0;
            end else begin
                if ((state == ST_LEN_LO) && xfer) len_lo <= in_data;
                if ((state == ST_LEN_HI) && xfer) n_len  <= len_full;
                if (asm_shift) xor_acc <= xor_acc ^ in_data;
                if (word_full) begin
                    mem_wdata <= asm_word;
                    mem_addr  <= {word_cnt[ADDR_WIDTH-1:0], 2'b00};
                    word_cnt  <= word_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table of whole frames with expected outcome,
// plus hand-written sequences for reset mid-frame and start mid-DATA.
module tb_instr_mem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW+1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   word_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .word_cnt  (word_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: records every memory write
    int          nwr = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    always @(negedge clk) begin
        if (mem_we) begin
            if (nwr < 64) begin
                wr_addr[nwr] = 32'(mem_addr);
                wr_data[nwr] = mem_wdata;
            end
            nwr++;
            check("hold_during_we", 32'(cpu_hold), 32'd1);
        end
    end

    typedef struct {
        int          nb;
        logic [7:0]  b [16];
        int          gap;
        logic        exp_done;
        logic        exp_err;
        int          exp_wr;
        logic [31:0] exp_w0;
        logic [31:0] exp_wl;
        int          exp_cnt;
    } vec_t;

    vec_t vt [7];

    task automatic set_vec(input int idx, input int nb, input logic [7:0] bs [16], input int gap,
                           input logic d, input logic e, input int wr,
                           input logic [31:0] w0, input logic [31:0] wl, input int cnt);
        vt[idx].nb = nb;
        for (int i = 0; i < 16; i++) vt[idx].b[i] = bs[i];
        vt[idx].gap      = gap;
        vt[idx].exp_done = d;
        vt[idx].exp_err  = e;
        vt[idx].exp_wr   = wr;
        vt[idx].exp_w0   = w0;
        vt[idx].exp_wl   = wl;
        vt[idx].exp_cnt  = cnt;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    // Offer one byte; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},    32'(mem_we),   32'd0);
        check({tag, "_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata,     32'd0);
        check({tag, "_hold"},  32'(cpu_hold), 32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_error"}, 32'(error),    32'd0);
        check({tag, "_cnt"},   32'(word_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int nw;
        logic [7:0] bs [16];

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // N=1 addi a0,x0,10 ; checksum B6 ; back-to-back
        bs = '{8'h01,8'h00,8'h13,8'h05,8'hA0,8'h00,8'hB6,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        set_vec(0, 7, bs, 0, 1'b1, 1'b0, 1, 32'h00A00513, 32'h00A00513, 1);
        // N=3 with in_valid every other cycle ; checksum 5A
        bs = '{8'h03,8'h00,8'h13,8'h05,8'hA0,8'h00,8'h93,8'h00,8'h10,8'h00,8'h6F,8'h00,8'h00,8'h00,8'h5A,8'h00};
        set_vec(1, 15, bs, 1, 1'b1, 1'b0, 3, 32'h00A00513, 32'h0000006F, 3);
        // Same as first frame but wrong checksum
        bs = '{8'h01,8'h00,8'h13,8'h05,8'hA0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        set_vec(2, 7, bs, 0, 1'b0, 1'b1, 1, 32'h00A00513, 32'h00A00513, 1);
        // Recovery with the good frame
        bs = '{8'h01,8'h00,8'h13,8'h05,8'hA0,8'h00,8'hB6,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        set_vec(3, 7, bs, 0, 1'b1, 1'b0, 1, 32'h00A00513, 32'h00A00513, 1);
        // N=1025 exceeds 2^10 words
        bs = '{8'h01,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        set_vec(4, 2, bs, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0, 0);
        // N=0, checksum 00
        bs = '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        set_vec(5, 3, bs, 0, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0);
        // N=0, checksum 5A
        bs = '{8'h00,8'h00,8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        set_vec(6, 3, bs, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0, 0);

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        for (int v = 0; v < 7; v++) begin
            base = nwr;
            pulse_start();
            for (int i = 0; i < vt[v].nb; i++) begin
                if (i > 0) repeat (vt[v].gap) @(negedge clk);
                send_byte(vt[v].b[i]);
            end
            // Terminal state is entered on the edge accepting the last byte
            check($sformatf("v%0d_done_edge", v), 32'(done), 32'(vt[v].exp_done));
            check($sformatf("v%0d_hold_edge", v), 32'(cpu_hold), 32'(!vt[v].exp_done));
            repeat (3) @(negedge clk);
            nw = nwr - base;
            check($sformatf("v%0d_done", v),   32'(done),     32'(vt[v].exp_done));
            check($sformatf("v%0d_error", v),  32'(error),    32'(vt[v].exp_err));
            check($sformatf("v%0d_hold", v),   32'(cpu_hold), 32'(!vt[v].exp_done));
            check($sformatf("v%0d_ready", v),  32'(in_ready), 32'd0);
            check($sformatf("v%0d_cnt", v),    32'(word_cnt), 32'(vt[v].exp_cnt));
            check($sformatf("v%0d_writes", v), 32'(nw),       32'(vt[v].exp_wr));
            if (nw == vt[v].exp_wr && nw > 0) begin
                for (int i = 0; i < nw; i++)
                    check($sformatf("v%0d_addr%0d", v, i), wr_addr[base+i], 32'(4*i));
                check($sformatf("v%0d_w0", v), wr_data[base], vt[v].exp_w0);
                check($sformatf("v%0d_wl", v), wr_data[base+nw-1], vt[v].exp_wl);
            end
        end

        // Reset asserted while the third data byte is on the bus
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h05);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Fresh frame with a start pulse in the middle of DATA
        base = nwr;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h05);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("middata_start_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'hA0); send_byte(8'h00);
        // Write appears one cycle after the fourth byte edge
        check("lat_we",    32'(mem_we),   32'd1);
        check("lat_addr",  32'(mem_addr), 32'd0);
        check("lat_wdata", mem_wdata,     32'h00A00513);
        check("lat_cnt",   32'(word_cnt), 32'd1);
        send_byte(8'hB6);
        repeat (2) @(negedge clk);
        check("reload_done",   32'(done),       32'd1);
        check("reload_error",  32'(error),      32'd0);
        check("reload_hold",   32'(cpu_hold),   32'd0);
        check("reload_writes", 32'(nwr - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
